// File: rtl/mode_sequencer_if.sv
// Button/vsync inputs and committed-mode outputs of the mode sequencer.
// The master side drives the raw inputs. The slave side is the sequencer itself.
interface mode_sequencer_if;
  logic       btn_next_i;
  logic       btn_prev_i;
  logic       btn_pass_i;
  logic       vs_i;
  logic [2:0] mode_o;
  logic       pending_o;
  logic       busy_o;
  logic       commit_o;

  modport master (
    output btn_next_i, btn_prev_i, btn_pass_i, vs_i,
    input  mode_o, pending_o, busy_o, commit_o
  );

  modport slave (
    input  btn_next_i, btn_prev_i, btn_pass_i, vs_i,
    output mode_o, pending_o, busy_o, commit_o
  );
endinterface

// File: rtl/mode_sequencer.sv
// Debounces next/prev/pass buttons into a target mode, and commits it only on a vsync tick.
// After each commit, a frame holdoff follows so downstream stages never see a mid-frame change.
module mode_sequencer #(
  parameter int DEBOUNCE_T     = 1000000,
  parameter int HOLDOFF_FRAMES = 2,
  parameter int N_MODES        = 8,
  parameter int RESET_MODE     = 0
) (
  input logic             clk_i,
  input logic             rst_i,
  mode_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_T + 1);
  localparam int HO_W  = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [2:0] MODE_PASS = 3'(N_MODES - 1);
  localparam logic [2:0] MODE_RST  = 3'(RESET_MODE);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_T);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  // bit 0 next, 1 prev, 2 pass, 3 vsync
  logic [3:0] raw;
  logic [3:0] sync_p0, sync_p1;
  assign raw = {bus.vs_i, bus.btn_pass_i, bus.btn_prev_i, bus.btn_next_i};

  // Stage p0/p1: two-flop synchronisers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce counters and vsync rising-edge tick
  logic [CNT_W-1:0] cnt_p2 [3];
  logic             vs_prev_p2, tick_p2;
  logic [2:0]       press;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) cnt_p2[i] <= '0;
      vs_prev_p2 <= 1'b0;
      tick_p2    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!sync_p1[i])
          cnt_p2[i] <= '0;
        else if (cnt_p2[i] != CNT_SAT)
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
      end
      vs_prev_p2 <= sync_p1[3];
      tick_p2    <= sync_p1[3] & ~vs_prev_p2;
    end
  end

  // The counter saturates one step past the fire value, so a held button pulses exactly once.
  always_comb begin
    for (int i = 0; i < 3; i++)
      press[i] = sync_p1[i] && (cnt_p2[i] == CNT_FIRE);
  end

  // Stage p3: target arithmetic, FSM and registered outputs
  logic [1:0]      state_p3, state_nx;
  logic [2:0]      mode_p3, mode_nx;
  logic [2:0]      tgt_p3, tgt_nx;
  logic [2:0]      last_p3, last_nx;
  logic [HO_W-1:0] hold_p3, hold_nx;
  logic            commit_p3, commit_nx;
  logic            pending_p3, pending_nx;
  logic            busy_p3, busy_nx;

  always_comb begin
    tgt_nx  = tgt_p3;
    last_nx = last_p3;
    if (press[2]) begin
      if (tgt_p3 != MODE_PASS) begin
        last_nx = tgt_p3;
        tgt_nx  = MODE_PASS;
      end else begin
        tgt_nx = last_p3;
      end
    end else if (press[0]) begin
      tgt_nx = (tgt_p3 == MODE_PASS) ? 3'd0 : 3'(tgt_p3 + 3'd1);
    end else if (press[1]) begin
      tgt_nx = (tgt_p3 == 3'd0) ? MODE_PASS : 3'(tgt_p3 - 3'd1);
    end
  end

  always_comb begin
    state_nx  = state_p3;
    mode_nx   = mode_p3;
    hold_nx   = hold_p3;
    commit_nx = 1'b0;
    case (state_p3)
      S_IDLE: begin
        if (tgt_nx != mode_p3) state_nx = S_PENDING;
      end
      S_PENDING: begin
        // A same-cycle press is folded in first; if it lands back on mode_o, nothing commits.
        if (tgt_nx == mode_p3) begin
          state_nx = S_IDLE;
        end else if (tick_p2) begin
          mode_nx   = tgt_nx;
          commit_nx = 1'b1;
          if (HOLDOFF_FRAMES > 0) begin
            hold_nx  = HO_W'(HOLDOFF_FRAMES);
            state_nx = S_HOLDOFF;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_HOLDOFF: begin
        if (tick_p2) begin
          hold_nx = (hold_p3 != '0) ? hold_p3 - HO_W'(1) : '0;
          if (hold_p3 <= HO_W'(1))
            state_nx = (tgt_nx != mode_p3) ? S_PENDING : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    pending_nx = (state_nx == S_PENDING) || ((state_nx == S_HOLDOFF) && (tgt_nx != mode_nx));
    busy_nx    = (state_nx == S_HOLDOFF);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p3   <= S_IDLE;
      mode_p3    <= MODE_RST;
      tgt_p3     <= MODE_RST;
      last_p3    <= MODE_RST;
      hold_p3    <= '0;
      commit_p3  <= 1'b0;
      pending_p3 <= 1'b0;
      busy_p3    <= 1'b0;
    end else begin
      state_p3   <= state_nx;
      mode_p3    <= mode_nx;
      tgt_p3     <= tgt_nx;
      last_p3    <= last_nx;
      hold_p3    <= hold_nx;
      commit_p3  <= commit_nx;
      pending_p3 <= pending_nx;
      busy_p3    <= busy_nx;
    end
  end

  assign bus.mode_o    = mode_p3;
  assign bus.pending_o = pending_p3;
  assign bus.busy_o    = busy_p3;
  assign bus.commit_o  = commit_p3;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with a cycle-level reference model.
// The model works from raw input run-lengths and fixed pipeline delays.
module tb_mode_sequencer;
  localparam int T  = 4;
  localparam int H  = 2;
  localparam int NM = 8;
  localparam int RM = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mode_sequencer_if bus();

  mode_sequencer #(.DEBOUNCE_T(T), .HOLDOFF_FRAMES(H), .N_MODES(NM), .RESET_MODE(RM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_commits = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a press lands two edges after the sample that completes a run of T highs.
  // A vsync rise lands three edges after it is first sampled.
  int  m_mode = RM, m_tgt = RM, m_last = RM, m_left = 0;
  bit  m_hold = 0, m_commit = 0;
  int  run [3] = '{0, 0, 0};
  bit  vs_prev = 0;
  int  pp [2] = '{0, 0};
  int  tp [3] = '{0, 0, 0};
  int  p_d, t_d, nt;
  bit  fire [3];
  bit  rawb [3];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = RM; m_tgt = RM; m_last = RM; m_left = 0; m_hold = 0; m_commit = 0;
      run = '{0, 0, 0}; vs_prev = 0; pp = '{0, 0}; tp = '{0, 0, 0};
    end else begin
      p_d = pp[1]; t_d = tp[2];
      pp[1] = pp[0]; tp[2] = tp[1]; tp[1] = tp[0];
      rawb[0] = bus.btn_next_i; rawb[1] = bus.btn_prev_i; rawb[2] = bus.btn_pass_i;
      for (int i = 0; i < 3; i++) begin
        run[i]  = rawb[i] ? ((run[i] <= T) ? run[i] + 1 : run[i]) : 0;
        fire[i] = rawb[i] && (run[i] == T);
      end
      pp[0] = fire[2] ? 3 : fire[0] ? 1 : fire[1] ? 2 : 0;
      tp[0] = (bus.vs_i && !vs_prev) ? 1 : 0;
      vs_prev = bus.vs_i;

      nt = m_tgt;
      case (p_d)
        3: if (m_tgt != NM - 1) begin m_last = m_tgt; nt = NM - 1; end else nt = m_last;
        1: nt = (m_tgt + 1) % NM;
        2: nt = (m_tgt + NM - 1) % NM;
        default: ;
      endcase
      m_commit = (t_d != 0) && !m_hold && (m_tgt != m_mode) && (nt != m_mode);
      if (m_hold && t_d != 0) begin
        m_left--;
        if (m_left == 0) m_hold = 0;
      end
      if (m_commit) begin
        m_mode = nt;
        if (H > 0) begin m_hold = 1; m_left = H; end
      end
      m_tgt = nt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("model_mode",    int'(bus.mode_o),    m_mode);
      chk("model_pending", int'(bus.pending_o), int'(m_tgt != m_mode));
      chk("model_busy",    int'(bus.busy_o),    int'(m_hold));
      chk("model_commit",  int'(bus.commit_o),  int'(m_commit));
      if (bus.commit_o) n_commits++;
    end
  end

  task automatic push(input bit nx, input bit pv, input bit ps, input int hold);
    @(negedge clk);
    bus.btn_next_i = nx; bus.btn_prev_i = pv; bus.btn_pass_i = ps;
    repeat (hold) @(negedge clk);
    bus.btn_next_i = 1'b0; bus.btn_prev_i = 1'b0; bus.btn_pass_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    bus.vs_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.vs_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_holdoff();
    frame();
    frame();
  endtask

  task automatic rst_pulse();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
  endtask

  int c0;

  initial begin
    bus.btn_next_i = 1'b0; bus.btn_prev_i = 1'b0; bus.btn_pass_i = 1'b0; bus.vs_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_mode",    int'(bus.mode_o),    0);
    chk("reset_pending", int'(bus.pending_o), 0);
    chk("reset_busy",    int'(bus.busy_o),    0);
    chk("reset_commit",  int'(bus.commit_o),  0);

    // Glitch rejection, then a held press
    push(1, 0, 0, 3);
    chk("glitch_pending", int'(bus.pending_o), 0);
    push(1, 0, 0, 20);
    chk("held_pending", int'(bus.pending_o), 1);
    chk("held_mode",    int'(bus.mode_o),    0);
    chk("held_commits", n_commits,           0);

    // Exact vsync-to-commit latency
    @(negedge clk); bus.vs_i = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 chk("lat_k2_mode", int'(bus.mode_o), 0);
    @(posedge clk);
    #1;
    chk("lat_k3_mode",    int'(bus.mode_o),    1);
    chk("lat_k3_commit",  int'(bus.commit_o),  1);
    chk("lat_k3_pending", int'(bus.pending_o), 0);
    chk("lat_k3_busy",    int'(bus.busy_o),    1);
    @(negedge clk); bus.vs_i = 1'b0;
    repeat (4) @(negedge clk);

    // Holdoff queuing
    push(1, 0, 0, 6);
    chk("hq_pending", int'(bus.pending_o), 1);
    c0 = n_commits;
    frame();
    chk("hq_t1_commits", n_commits - c0, 0);
    chk("hq_t1_busy",    int'(bus.busy_o), 1);
    chk("hq_t1_pending", int'(bus.pending_o), 1);
    frame();
    chk("hq_t2_commits", n_commits - c0, 0);
    chk("hq_t2_busy",    int'(bus.busy_o), 0);
    chk("hq_t2_pending", int'(bus.pending_o), 1);
    frame();
    chk("hq_t3_commits", n_commits - c0, 1);
    chk("hq_t3_mode",    int'(bus.mode_o), 2);
    clear_holdoff();

    // Accumulation and wrap
    rst_pulse();
    push(0, 1, 0, 6);
    push(0, 1, 0, 6);
    chk("acc_pending", int'(bus.pending_o), 1);
    chk("acc_mode0",   int'(bus.mode_o), 0);
    frame();
    chk("acc_mode6", int'(bus.mode_o), 6);
    clear_holdoff();
    push(1, 0, 0, 6);
    frame();
    chk("wrap_mode7", int'(bus.mode_o), 7);
    clear_holdoff();
    push(1, 0, 0, 6);
    frame();
    chk("wrap_mode0", int'(bus.mode_o), 0);
    clear_holdoff();

    // Pass toggle and simultaneous presses
    push(1, 0, 0, 6); push(1, 0, 0, 6); push(1, 0, 0, 6);
    frame();
    chk("to_mode3", int'(bus.mode_o), 3);
    clear_holdoff();
    push(1, 0, 1, 6);
    frame();
    chk("pass_next_mode", int'(bus.mode_o), 7);
    clear_holdoff();
    push(0, 0, 1, 6);
    frame();
    chk("pass_back_mode", int'(bus.mode_o), 3);
    clear_holdoff();
    c0 = n_commits;
    push(1, 0, 0, 6);
    chk("cancel_pending1", int'(bus.pending_o), 1);
    push(0, 1, 0, 6);
    chk("cancel_pending0", int'(bus.pending_o), 0);
    frame();
    chk("cancel_commits", n_commits - c0, 0);
    chk("cancel_mode",    int'(bus.mode_o), 3);

    // Asynchronous reset while pending
    push(1, 0, 0, 6);
    chk("rp_pending", int'(bus.pending_o), 1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rp_async_mode",    int'(bus.mode_o),    0);
    chk("rp_async_pending", int'(bus.pending_o), 0);
    chk("rp_async_busy",    int'(bus.busy_o),    0);
    @(negedge clk); #2 rst = 1'b0;
    c0 = n_commits;
    frame();
    chk("rp_commits", n_commits - c0, 0);
    chk("rp_mode",    int'(bus.mode_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
